// File: rtl/seq_adc.sv
// -----------------------------------------------------------------------------
// seq_adc : multi-cycle add/subtract-with-carry unit.
//
// A narrow CHUNK-bit adder is reused over NCHUNK = WIDTH/CHUNK clock cycles.
// The LSB chunk is processed first, and a carry register ripples between chunks.
// Subtraction uses a + ~b + ~C0, so C0 acts as a borrow-in and Co=1 means
// "no borrow".
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous reset, active low
//   start  : operation request; sampled only in IDLE and DONE
//   sub    : 0 = ai+bi+C0, 1 = ai-bi-C0
//   ai, bi : WIDTH-bit operands
//   C0     : carry-in (borrow-in when sub=1)
//   busy   : high while chunks are being processed
//   done   : one-cycle pulse in the cycle after the result registers update
//   s      : result (holds until the next completion)
//   Co     : carry-out / not-borrow
//   ovf    : two's-complement overflow
//   zero   : s == 0
//
// Parameters
//   WIDTH  : operand width; CHUNK must divide it
//   CHUNK  : bits per cycle; CHUNK == WIDTH gives a single processing cycle
// -----------------------------------------------------------------------------
module seq_adc #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] ai,
    input  logic [WIDTH-1:0] bi,
    input  logic             C0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             Co,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    // The operand registers shift right one chunk per cycle, so the active chunk
    // is always in the low CHUNK bits. No variable part-select is needed.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    // Partial sums enter from the top and shift down. After NCHUNK steps,
    // chunk 0 has reached the LSB position.
    logic [WIDTH-1:0] r_partial;
    logic [WIDTH-1:0] r_s;
    logic             r_co;
    logic             r_ovf;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;

    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_partial_next;
    logic             w_msb_cin;
    logic [WIDTH-1:0] w_b_load;
    logic             w_cin_load;

    // Operand transform applied at acceptance: subtraction becomes a + ~b + ~C0.
    always_comb begin
        w_b_load   = sub ? ~bi : bi;
        w_cin_load = sub ? ~C0 : C0;
    end

    // Chunk adder (CHUNK+1 bits wide) and the next value of the partial-sum register.
    always_comb begin
        w_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
        w_partial_next = (r_partial >> CHUNK)
                       | (WIDTH'(w_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        // On the last chunk the low bits hold the original operand MSBs.
        // a ^ b ^ sum at that bit therefore gives the carry into the MSB.
        w_msb_cin = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_sum[CHUNK-1];
    end

    // Control FSM, chunk datapath and registered result/flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_carry   <= 1'b0;
            r_partial <= '0;
            r_s       <= '0;
            r_co      <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= ai;
                        r_b     <= w_b_load;
                        r_carry <= w_cin_load;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_a       <= r_a >> CHUNK;
                    r_b       <= r_b >> CHUNK;
                    r_carry   <= w_sum[CHUNK];
                    r_partial <= w_partial_next;
                    if (r_cnt == LAST_IDX) begin
                        r_s     <= w_partial_next;
                        r_co    <= w_sum[CHUNK];
                        r_ovf   <= w_msb_cin ^ w_sum[CHUNK];
                        r_zero  <= (w_partial_next == {WIDTH{1'b0}});
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b0;
                    // A start seen during DONE is accepted with no idle gap.
                    if (start) begin
                        r_a     <= ai;
                        r_b     <= w_b_load;
                        r_carry <= w_cin_load;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign Co   = r_co;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule

// File: tb/tb_seq_adc.sv
// -----------------------------------------------------------------------------
// tb_seq_adc : self-checking bench for seq_adc.
//
// Two instances are tested:
//   - WIDTH=32, CHUNK=8
//   - WIDTH=16, CHUNK=16
// Expected results come from an arithmetic reference model that works on
// signed and unsigned integer values.
// -----------------------------------------------------------------------------
module tb_seq_adc;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    // 32/8 instance
    logic        a_start = 1'b0;
    logic        a_sub   = 1'b0;
    logic        a_c0    = 1'b0;
    logic [31:0] a_ai    = 32'd0;
    logic [31:0] a_bi    = 32'd0;
    logic        a_busy, a_done, a_co, a_ovf, a_zero;
    logic [31:0] a_s;

    // 16/16 instance
    logic        b_start = 1'b0;
    logic        b_sub   = 1'b0;
    logic        b_c0    = 1'b0;
    logic [15:0] b_ai    = 16'd0;
    logic [15:0] b_bi    = 16'd0;
    logic        b_busy, b_done, b_co, b_ovf, b_zero;
    logic [15:0] b_s;

    int n_vec = 0;
    int n_err = 0;

    // Currently held result of each instance, as the model sees it
    longint unsigned ea_s = 64'd0;
    bit              ea_co = 1'b0, ea_ovf = 1'b0, ea_zero = 1'b0;
    longint unsigned eb_s = 64'd0;
    bit              eb_co = 1'b0, eb_ovf = 1'b0, eb_zero = 1'b0;

    time t_done = 0;

    seq_adc #(.WIDTH(32), .CHUNK(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .sub(a_sub),
        .ai(a_ai), .bi(a_bi), .C0(a_c0),
        .busy(a_busy), .done(a_done), .s(a_s), .Co(a_co), .ovf(a_ovf), .zero(a_zero)
    );

    seq_adc #(.WIDTH(16), .CHUNK(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .sub(b_sub),
        .ai(b_ai), .bi(b_bi), .C0(b_c0),
        .busy(b_busy), .done(b_done), .s(b_s), .Co(b_co), .ovf(b_ovf), .zero(b_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the unsigned and signed
    // interpretations of the operands.
    function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                  input bit c, input bit sb,
                                  output longint unsigned rs, output bit rco,
                                  output bit rovf, output bit rz);
        longint unsigned m;
        longint          half, sa, sbb, r;
        m    = 64'd1 << w;
        half = longint'(m >> 1);
        sa   = (a >= (m >> 1)) ? longint'(a) - longint'(m) : longint'(a);
        sbb  = (b >= (m >> 1)) ? longint'(b) - longint'(m) : longint'(b);
        if (sb) begin
            rs  = (a + m - b - longint'(c)) % m;
            rco = (a >= b + longint'(c));
            r   = sa - sbb - longint'(c);
        end else begin
            rs  = (a + b + longint'(c)) % m;
            rco = ((a + b + longint'(c)) >= m);
            r   = sa + sbb + longint'(c);
        end
        rovf = (r >= half) || (r < -half);
        rz   = (rs == 64'd0);
    endfunction

    // Runs one operation on the 32/8 instance.
    // aligned: we are already at a negedge, e.g. the DONE cycle of a previous op.
    // noise:   assert start with junk operands while the unit is busy.
    // Returns at the negedge where done is high, with start driven low.
    task automatic op_a(input logic [31:0] a, input logic [31:0] b, input logic c, input logic sb,
                        input bit aligned, input bit noise);
        longint unsigned ns;
        bit nco, novf, nz;
        int k;
        if (!aligned) @(negedge clk);
        a_start = 1'b1; a_ai = a; a_bi = b; a_c0 = c; a_sub = sb;
        model(32, a, b, c, sb, ns, nco, novf, nz);
        @(posedge clk);
        @(negedge clk);
        k = 1;
        while (a_done !== 1'b1 && k <= 12) begin
            check("a_busy", a_busy, 64'd1);
            check("a_hold_s", a_s, ea_s);
            a_start = noise;
            a_ai = $urandom; a_bi = $urandom; a_c0 = 1'($urandom); a_sub = 1'($urandom);
            @(negedge clk);
            k++;
        end
        a_start = 1'b0;
        t_done = $time;
        check("a_latency", k, 64'd5);
        check("a_busy_in_done", a_busy, 64'd0);
        ea_s = ns; ea_co = nco; ea_ovf = novf; ea_zero = nz;
        check("a_s", a_s, ea_s);
        check("a_co", a_co, ea_co);
        check("a_ovf", a_ovf, ea_ovf);
        check("a_zero", a_zero, ea_zero);
    endtask

    // Runs one operation on the single-chunk 16/16 instance.
    task automatic op_b(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sb);
        longint unsigned ns;
        bit nco, novf, nz;
        int k;
        @(negedge clk);
        b_start = 1'b1; b_ai = a; b_bi = b; b_c0 = c; b_sub = sb;
        model(16, a, b, c, sb, ns, nco, novf, nz);
        @(posedge clk);
        @(negedge clk);
        k = 1;
        while (b_done !== 1'b1 && k <= 6) begin
            check("b_busy", b_busy, 64'd1);
            check("b_hold_s", b_s, eb_s);
            b_start = 1'b0;
            b_ai = 16'($urandom); b_bi = 16'($urandom);
            @(negedge clk);
            k++;
        end
        b_start = 1'b0;
        check("b_latency", k, 64'd2);
        eb_s = ns; eb_co = nco; eb_ovf = novf; eb_zero = nz;
        check("b_s", b_s, eb_s);
        check("b_co", b_co, eb_co);
        check("b_ovf", b_ovf, eb_ovf);
        check("b_zero", b_zero, eb_zero);
    endtask

    initial begin
        time t1;
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", a_busy, 64'd0);
        check("rst_done", a_done, 64'd0);
        check("rst_s", a_s, 64'd0);
        check("rst_flags", {a_co, a_ovf, a_zero}, 64'd0);
        check("rst_b_s", b_s, 64'd0);
        rst_n = 1'b1;

        // Unsigned wrap
        op_a(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap_s", a_s, 64'h0);
        check("wrap_flags", {a_co, a_ovf, a_zero}, 64'b101);
        @(negedge clk);
        check("wrap_done_once", a_done, 64'd0);

        // Signed overflow
        op_a(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sovf_s", a_s, 64'h8000_0000);
        check("sovf_flags", {a_co, a_ovf, a_zero}, 64'b010);

        // Carry-in ripples across a chunk boundary
        op_a(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        check("cin_s", a_s, 64'h100);

        // Subtraction cases
        op_a(32'd5, 32'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        check("sub1_s", a_s, 64'hFFFF_FFFE);
        check("sub1_flags", {a_co, a_ovf}, 64'b00);
        op_a(32'd10, 32'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        check("sub2_s", a_s, 64'd6);
        check("sub2_co", a_co, 64'd1);
        op_a(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("sub3_s", a_s, 64'h7FFF_FFFF);
        check("sub3_ovf", a_ovf, 64'd1);

        // Start during busy is ignored
        op_a(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ign_s", a_s, 64'h2345_6789);
        @(negedge clk);
        check("ign_done_once", a_done, 64'd0);

        // Back-to-back: start held during the DONE cycle
        op_a(32'd100, 32'd23, 1'b0, 1'b0, 1'b0, 1'b0);
        t1 = t_done;
        op_a(32'd100, 32'd23, 1'b0, 1'b1, 1'b1, 1'b0);
        check("b2b_gap", t_done - t1, 64'd50);
        check("b2b_s", a_s, 64'd77);

        // Reset in the middle of an operation
        @(negedge clk);
        a_start = 1'b1; a_ai = 32'hDEAD_BEEF; a_bi = 32'h0101_0101; a_c0 = 1'b0; a_sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", a_busy, 64'd0);
        check("mid_rst_done", a_done, 64'd0);
        check("mid_rst_s", a_s, 64'd0);
        check("mid_rst_flags", {a_co, a_ovf, a_zero}, 64'd0);
        ea_s = 64'd0; ea_co = 1'b0; ea_ovf = 1'b0; ea_zero = 1'b0;
        eb_s = 64'd0; eb_co = 1'b0; eb_ovf = 1'b0; eb_zero = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_rst_no_done", a_done, 64'd0);
        end
        op_a(32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        check("after_rst_s", a_s, 64'd7);

        // Random operations
        for (int i = 0; i < 20; i++) begin
            op_a($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
        end

        // Sweep on both instances
        for (int x = 0; x <= 65535; x += 10000) begin
            for (int y = 0; y <= 65535; y += 10000) begin
                for (int m = 0; m < 4; m++) begin
                    op_a(32'(x), 32'(y), m[0], m[1], 1'b0, 1'b0);
                    op_b(16'(x), 16'(y), m[0], m[1]);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
